bus_rw_ctrl: RTL
================

Name: bus_rw_ctrl

Overview:
Registered, parametrised successor to the combinational idle/read/write/stable bus FSM. Accepts single read or write requests from a requester, then drives the memory-side valid/rw strobes for configurable dwell times. Registers the address and write data, and captures read data. Sits between the datapath controller and the on-chip memory or register bank.

Parameters:
ADDR_W, 8, address width in bits
DATA_W, 8, data width in bits
READ_CYCLES, 1, cycles spent in READ (must be >=1)
WRITE_CYCLES, 1, cycles spent in WRITE (must be >=1)
STABLE_CYCLES, 1, post-write hold cycles in STABLE (0 means STABLE is skipped)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active high
select  in  1  request strobe; sampled only when ready=1
op  in  1  1 = write, 0 = read; sampled with select
addr  in  ADDR_W  request address; sampled with select
wdata  in  DATA_W  write data; sampled with select
ready  out  1  high in IDLE; request accepted on the edge where select&ready
done  out  1  one-cycle pulse on completion of any access
rdata  out  DATA_W  captured read data; holds its value until the next read completes
rdata_valid  out  1  one-cycle pulse when rdata updates
valid  out  1  memory access strobe
rw  out  1  memory direction: 1 = write, 0 = read
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  memory read data
state_o  out  2  current state (IDLE=00, WRITE=01, READ=10, STABLE=11)

Behaviour:
- State register and dwell counter are clocked. valid and rw are Moore-decoded from state:
  - IDLE: valid=0, rw=0
  - WRITE: valid=1, rw=1
  - READ: valid=1, rw=0
  - STABLE: valid=0, rw=1
- Reset (rst=1 at an edge, including mid-access):
  - state=IDLE, counter=0
  - valid=0, rw=0, done=0, rdata_valid=0
  - rdata=0, mem_addr=0, mem_wdata=0
  - ready=1 in the first cycle after reset is released.
- IDLE:
  - If select=1 at an edge: latch addr into mem_addr; for a write, also latch wdata into mem_wdata; reset the counter.
  - Next state is WRITE if op=1, else READ.
  - If select=0, remain in IDLE.
- Latency: request accepted at edge E0, so valid=1 in the cycle following E0.
- WRITE: held for exactly WRITE_CYCLES cycles. Then go to STABLE if STABLE_CYCLES>0, else go directly to IDLE.
- STABLE: held for exactly STABLE_CYCLES cycles, then go to IDLE.
- READ: held for exactly READ_CYCLES cycles. On the edge leaving READ, rdata <= mem_rdata.
- done: registered; high for the first IDLE cycle after any access completes. rdata_valid is high in that same cycle, for reads only.
- Back-to-back: ready=1 in the done cycle, so a new request may be accepted there. Minimum request spacing is access length + 1 cycle.
- While ready=0, select/op/addr/wdata are ignored. There is no queueing, and mem_addr/mem_wdata stay stable for the whole access.
- A read leaves mem_wdata unchanged.
- The counter is sized for max(READ_CYCLES, WRITE_CYCLES, STABLE_CYCLES) and does not wrap within a state.
- The default parameters reproduce the legacy sequences: IDLE-WRITE-STABLE-IDLE and IDLE-READ-IDLE, each state lasting one cycle.
- Unreachable encodings: none exist (all four encodings are used). Any illegal value forces IDLE.

Test Plan:
- Reset: rst high 2 cycles with select=1 -> ready=1, valid=0, rw=0, done=0, rdata=0, state_o=00; no request accepted while rst=1.
- Default write: select=1, op=1, addr=0x3C, wdata=0x5A at E0 -> cycle1 valid=1 rw=1 mem_addr=0x3C mem_wdata=0x5A; cycle2 valid=0 rw=1; cycle3 IDLE with done=1 and rdata_valid=0.
- Read with READ_CYCLES=3: select=1, op=0, addr=0x10, mem_rdata=0xA5 -> valid=1 rw=0 for 3 cycles; next cycle rdata=0xA5, rdata_valid=1, done=1.
- WRITE_CYCLES=2, STABLE_CYCLES=0: one write -> WRITE for 2 cycles, no STABLE, then IDLE with done=1; sequence lasts 3 cycles from acceptance.
- Busy rejection: a second select=1 with addr=0x77 during WRITE -> ignored and mem_addr unchanged; a select issued in the done cycle -> accepted, valid=1 on the next cycle.
- Reset mid-access: rst=1 during READ with READ_CYCLES=4 -> next cycle IDLE, valid=0, no done or rdata_valid pulse, rdata=0.

Source files
------------

// File: rtl/bus_rw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bus_rw_ctrl
//  Description : Registered single-request bus controller. Accepts one read
//                or write request at a time, drives memory valid/rw strobes
//                for configurable dwell times, latches address/write data and
//                captures read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_rw_ctrl #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int READ_CYCLES   = 1,
    parameter int WRITE_CYCLES  = 1,
    parameter int STABLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              select,
    input  logic              op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              valid,
    output logic              rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        state_o
);

    // Counter only has to reach the longest dwell minus one.
    localparam int MAX_RW     = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int MAX_CYCLES = (MAX_RW > STABLE_CYCLES) ? MAX_RW : STABLE_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int S_LAST_I   = (STABLE_CYCLES > 0) ? STABLE_CYCLES - 1 : 0;

    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WRITE_CYCLES - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(S_LAST_I);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_WRITE  = 2'b01,
        S_READ   = 2'b10,
        S_STABLE = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                done_q, done_d;
    logic                rdata_valid_q, rdata_valid_d;

    // State register, dwell counter and latched data; reset has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rdata_q       <= '0;
            done_q        <= 1'b0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_q       <= rdata_d;
            done_q        <= done_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    // Next-state, dwell counting, request capture and completion pulses.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_d       = rdata_q;
        done_d        = 1'b0;
        rdata_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (select) begin
                    mem_addr_d = addr;
                    if (op) begin
                        mem_wdata_d = wdata;
                    end
                    cnt_d   = '0;
                    state_d = op ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (cnt_q == W_LAST) begin
                    cnt_d = '0;
                    if (STABLE_CYCLES > 0) begin
                        state_d = S_STABLE;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STABLE: begin
                if (cnt_q == S_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_READ: begin
                if (cnt_q == R_LAST) begin
                    cnt_d         = '0;
                    state_d       = S_IDLE;
                    done_d        = 1'b1;
                    rdata_valid_d = 1'b1;
                    rdata_d       = mem_rdata;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore decode of the memory strobes from the current state.
    always_comb begin
        valid = 1'b0;
        rw    = 1'b0;
        case (state_q)
            S_WRITE:  begin valid = 1'b1; rw = 1'b1; end
            S_READ:   begin valid = 1'b1; rw = 1'b0; end
            S_STABLE: begin valid = 1'b0; rw = 1'b1; end
            default:  begin valid = 1'b0; rw = 1'b0; end
        endcase
    end

    assign ready       = (state_q == S_IDLE);
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign state_o     = state_q;

endmodule
`default_nettype wire
